am4_qbus_seq: RTL and testbench
===============================

Name: am4_qbus_seq

Overview:
Q-bus master cycle sequencer and DMA grant arbiter for the am4 core.
- Accepts one internal transfer request at a time: read, write, read-modify-write or interrupt-acknowledge.
- Sequences the address, SYNC, DIN/DOUT and RPLY handshake phases on the Q-bus pins.
- Arbitrates bus mastership between the core and external DMA masters (DMR/DMGO/SACK).
- All transitions occur on pin_clk.

Parameters:
TOUT_CYCLES, 64, pin_clk cycles to wait for RPLY in a data phase before bus error (range 2..255; 8-bit counter)

Ports:
pin_clk  in  1  processor clock
pin_dclo  in  1  asynchronous active-high reset
req_start  in  1  transfer request strobe; accepted only when req_rdy=1
req_wr  in  1  1=write, 0=read
req_byte  in  1  byte write (WTBT in data phase)
req_rmw  in  1  read-modify-write (read then write under one SYNC)
req_iak  in  1  interrupt vector read (no address phase)
req_addr  in  16  transfer address
req_data  in  16  write data, sampled at DOUT phase entry
req_rdy  out  1  sequencer idle and bus owned by core
req_ack  out  1  one-cycle pulse: transfer completed
req_err  out  1  one-cycle pulse: RPLY timeout
rd_data  out  16  latched read/vector data, valid from req_ack
pin_rply  in  1  transaction acknowledge
pin_ad_in  in  16  AD bus input
pin_ad_out  out  16  AD bus output
pin_ad_ena  out  1  AD output enable
pin_ctrl_ena  out  1  SYNC/DIN/DOUT/WTBT/IAKO output enable
pin_sync  out  1  address strobe
pin_din  out  1  data input strobe
pin_dout  out  1  data output strobe
pin_wtbt  out  1  write/byte status
pin_iako  out  1  interrupt acknowledge out
pin_dmr  in  1  DMA request
pin_sack  in  1  DMA selection acknowledge
pin_dmgo  out  1  DMA grant

Behaviour:
- Reset (pin_dclo=1, async): state IDLE; all outputs 0 except req_rdy=0; rd_data=0; timeout counter=0. Aborts any cycle or grant immediately. req_rdy=1 one cycle after reset release.
- States: IDLE, ADDR, ASYN, DATA, DEND, SEND, GRANT, DMA.
- IDLE: req_rdy=1; all pins 0.
  - pin_dmr=1 → GRANT; DMA wins over a same-cycle req_start, which is ignored.
  - Else req_start=1 → latch req_*.
    - req_iak=1 → DATA (read, no address phase).
    - Otherwise → ADDR.
- ADDR, 1 cycle: ad_ena=1, ad_out=addr, ctrl_ena=1, wtbt=req_wr|req_rmw.
- ASYN, 1 cycle: as ADDR plus sync=1.
- DATA: ctrl_ena=1; sync=1 unless iak.
  - Read phase: ad_ena=0, din=1, iako=iak.
  - Write phase: ad_ena=1, ad_out=data, dout=1, wtbt=byte.
  - Timeout counter cleared on entry, +1 per cycle.
  - pin_rply=1 → latch pin_ad_in into rd_data if read; → DEND.
- DEND: din/dout/iako=0; sync held; wait pin_rply=0.
  - Read phase with rmw → DATA (write phase).
  - Otherwise → SEND.
- SEND, 1 cycle: sync=0, ctrl_ena=1, req_ack=1 → IDLE.
  - Minimum read/write: 5 cycles start→ack when RPLY answers in 1 cycle.
- Timeout: counter reaches TOUT_CYCLES in DATA or DEND → drop strobes, → SEND with req_err=1 instead of req_ack; rd_data unchanged.
- GRANT: dmgo=1.
  - pin_sack=1 → dmgo=0, → DMA.
  - pin_dmr=0 and pin_sack=0 → IDLE (request withdrawn).
- DMA: all outputs released (ad_ena=ctrl_ena=0); req_rdy=0; pin_sack=0 → IDLE.
- RPLY still high on DATA entry: not accepted until it has been seen low once (stale-RPLY guard).

Optional Feature:
AM4_QSEQ_TIMEOUT_EN
- Defined: RPLY timeout counter and req_err behave as above.
- Undefined: counter removed; req_err tied 0; DATA/DEND wait indefinitely for RPLY; TOUT_CYCLES ignored.

Test Plan:
- Read 0x1000, RPLY after 2 cycles with AD=0xBEEF → SYNC before DIN; rd_data=0xBEEF; req_ack one pulse; 6 cycles start→ack.
- Byte write 0x2001/0x00AA → wtbt=1 in ADDR; DOUT with ad_out=0x00AA and wtbt=1; ack after RPLY falls.
- RMW at 0x3000, read 0x1234, write 0x5678 → single SYNC spanning DIN then DOUT; rd_data=0x1234.
- IAK read, vector 0x0060 → no ADDR/ASYN; sync=0; din=iako=1; rd_data=0x0060.
- No RPLY, TOUT_CYCLES=64, macro defined → req_err after 64 DATA cycles; strobes drop; IDLE.
- DMR asserted with same-cycle req_start → dmgo=1; SACK → dmgo=0 and all enables 0; SACK drop → req_rdy=1; pin_dclo mid-DATA → all outputs 0 asynchronously.

Source files
------------

// File: rtl/am4_qbus_seq.sv
// Q-bus master cycle sequencer with DMA grant arbitration for the am4 core.
// Optional: define AM4_QSEQ_TIMEOUT_EN to enable the RPLY timeout / req_err path.
module am4_qbus_seq #(
  parameter int TOUT_CYCLES = 64
) (
  input  logic        pin_clk,
  input  logic        pin_dclo,
  input  logic        req_start,
  input  logic        req_wr,
  input  logic        req_byte,
  input  logic        req_rmw,
  input  logic        req_iak,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_data,
  output logic        req_rdy,
  output logic        req_ack,
  output logic        req_err,
  output logic [15:0] rd_data,
  input  logic        pin_rply,
  input  logic [15:0] pin_ad_in,
  output logic [15:0] pin_ad_out,
  output logic        pin_ad_ena,
  output logic        pin_ctrl_ena,
  output logic        pin_sync,
  output logic        pin_din,
  output logic        pin_dout,
  output logic        pin_wtbt,
  output logic        pin_iako,
  input  logic        pin_dmr,
  input  logic        pin_sack,
  output logic        pin_dmgo
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_ASYN  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DEND  = 3'd4;
  localparam logic [2:0] S_SEND  = 3'd5;
  localparam logic [2:0] S_GRANT = 3'd6;
  localparam logic [2:0] S_DMA   = 3'd7;

  logic [2:0]  state, state_nx;
  logic        rdy_q;
  logic        wr_q, byte_q, rmw_q, iak_q;
  logic        wphase_q;
  logic        armed_q;
  logic [15:0] addr_q, data_q;
  logic        tout;
  logic        rply_ok;

  // RPLY counts only once it has been observed low since the data phase began.
  assign rply_ok = pin_rply && armed_q;

`ifdef AM4_QSEQ_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;

  assign tout = (state == S_DATA || state == S_DEND) &&
                (cnt_q == 8'(TOUT_CYCLES - 1));

  always_ff @(posedge pin_clk or posedge pin_dclo) begin
    if (pin_dclo) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_nx == S_DATA && state != S_DATA)
        cnt_q <= '0;
      else if (state == S_DATA || state == S_DEND)
        cnt_q <= cnt_q + 8'd1;
      // The only non-error way into SEND is DEND seeing RPLY released.
      if (state_nx == S_SEND)
        err_q <= !(state == S_DEND && !pin_rply);
    end
  end

  assign req_ack = (state == S_SEND) && !err_q;
  assign req_err = (state == S_SEND) && err_q;
`else
  assign tout    = 1'b0;
  assign req_ack = (state == S_SEND);
  assign req_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:
        if (rdy_q) begin
          if (pin_dmr)        state_nx = S_GRANT;
          else if (req_start) state_nx = req_iak ? S_DATA : S_ADDR;
        end
      S_ADDR: state_nx = S_ASYN;
      S_ASYN: state_nx = S_DATA;
      S_DATA:
        if (rply_ok)   state_nx = S_DEND;
        else if (tout) state_nx = S_SEND;
      S_DEND:
        if (!pin_rply) state_nx = (rmw_q && !wphase_q) ? S_DATA : S_SEND;
        else if (tout) state_nx = S_SEND;
      S_SEND: state_nx = S_IDLE;
      S_GRANT:
        if (pin_sack)      state_nx = S_DMA;
        else if (!pin_dmr) state_nx = S_IDLE;
      S_DMA:
        if (!pin_sack) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge pin_clk or posedge pin_dclo) begin
    if (pin_dclo) begin
      state    <= S_IDLE;
      rdy_q    <= 1'b0;
      wr_q     <= 1'b0;
      byte_q   <= 1'b0;
      rmw_q    <= 1'b0;
      iak_q    <= 1'b0;
      wphase_q <= 1'b0;
      armed_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rd_data  <= '0;
    end else begin
      state <= state_nx;
      rdy_q <= 1'b1;
      case (state)
        S_IDLE:
          if (rdy_q && !pin_dmr && req_start) begin
            wr_q     <= req_wr;
            byte_q   <= req_byte;
            rmw_q    <= req_rmw && !req_iak;
            iak_q    <= req_iak;
            addr_q   <= req_addr;
            wphase_q <= req_wr && !req_rmw && !req_iak;
            armed_q  <= !pin_rply;
          end
        S_ASYN: begin
          armed_q <= !pin_rply;
          if (wphase_q) data_q <= req_data;
        end
        S_DATA: begin
          if (!pin_rply) armed_q <= 1'b1;
          if (rply_ok && !wphase_q) rd_data <= pin_ad_in;
        end
        S_DEND:
          // RMW turnaround: SYNC stays up, the write half begins here.
          if (!pin_rply && rmw_q && !wphase_q) begin
            wphase_q <= 1'b1;
            data_q   <= req_data;
            armed_q  <= 1'b1;
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_rdy      = (state == S_IDLE) && rdy_q;
    pin_ad_out   = '0;
    pin_ad_ena   = 1'b0;
    pin_ctrl_ena = 1'b0;
    pin_sync     = 1'b0;
    pin_din      = 1'b0;
    pin_dout     = 1'b0;
    pin_wtbt     = 1'b0;
    pin_iako     = 1'b0;
    pin_dmgo     = 1'b0;
    case (state)
      S_ADDR, S_ASYN: begin
        pin_ad_ena   = 1'b1;
        pin_ad_out   = addr_q;
        pin_ctrl_ena = 1'b1;
        pin_wtbt     = wr_q || rmw_q;
        pin_sync     = (state == S_ASYN);
      end
      S_DATA: begin
        pin_ctrl_ena = 1'b1;
        pin_sync     = !iak_q;
        if (wphase_q) begin
          pin_ad_ena = 1'b1;
          pin_ad_out = data_q;
          pin_dout   = 1'b1;
          pin_wtbt   = byte_q;
        end else begin
          pin_din  = 1'b1;
          pin_iako = iak_q;
        end
      end
      S_DEND: begin
        pin_ctrl_ena = 1'b1;
        pin_sync     = !iak_q;
        pin_ad_ena   = wphase_q;
        pin_ad_out   = wphase_q ? data_q : 16'h0000;
      end
      S_SEND:  pin_ctrl_ena = 1'b1;
      S_GRANT: pin_dmgo     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_am4_qbus_seq.sv
// Directed bench for am4_qbus_seq: per-cycle pin checks plus a completion scoreboard.
module tb_am4_qbus_seq;

  logic        pin_clk = 1'b0;
  logic        pin_dclo = 1'b1;
  logic        req_start = 1'b0, req_wr = 1'b0, req_byte = 1'b0, req_rmw = 1'b0, req_iak = 1'b0;
  logic [15:0] req_addr = '0, req_data = '0;
  logic        req_rdy, req_ack, req_err;
  logic [15:0] rd_data;
  logic        pin_rply = 1'b0;
  logic [15:0] pin_ad_in = '0;
  logic [15:0] pin_ad_out;
  logic        pin_ad_ena, pin_ctrl_ena, pin_sync, pin_din, pin_dout, pin_wtbt, pin_iako;
  logic        pin_dmr = 1'b0, pin_sack = 1'b0;
  logic        pin_dmgo;

  am4_qbus_seq #(.TOUT_CYCLES(64)) dut (
    .pin_clk(pin_clk), .pin_dclo(pin_dclo),
    .req_start(req_start), .req_wr(req_wr), .req_byte(req_byte), .req_rmw(req_rmw),
    .req_iak(req_iak), .req_addr(req_addr), .req_data(req_data),
    .req_rdy(req_rdy), .req_ack(req_ack), .req_err(req_err), .rd_data(rd_data),
    .pin_rply(pin_rply), .pin_ad_in(pin_ad_in), .pin_ad_out(pin_ad_out),
    .pin_ad_ena(pin_ad_ena), .pin_ctrl_ena(pin_ctrl_ena), .pin_sync(pin_sync),
    .pin_din(pin_din), .pin_dout(pin_dout), .pin_wtbt(pin_wtbt), .pin_iako(pin_iako),
    .pin_dmr(pin_dmr), .pin_sack(pin_sack), .pin_dmgo(pin_dmgo)
  );

  always #5 pin_clk = ~pin_clk;

  // {rdy,ack,err | ad_ena,ctrl_ena,sync,din | dout,wtbt,iako,dmgo}
  wire [10:0] ov = {req_rdy, req_ack, req_err, pin_ad_ena, pin_ctrl_ena, pin_sync,
                    pin_din, pin_dout, pin_wtbt, pin_iako, pin_dmgo};

  localparam logic [10:0] O_ZERO  = 11'b000_0000_0000;
  localparam logic [10:0] O_IDLE  = 11'b100_0000_0000;
  localparam logic [10:0] O_SEND  = 11'b010_0100_0000;
  localparam logic [10:0] O_SERR  = 11'b001_0100_0000;
  localparam logic [10:0] O_DRD   = 11'b000_0111_0000;
  localparam logic [10:0] O_DENDR = 11'b000_0110_0000;
  localparam logic [10:0] O_DENDW = 11'b000_1110_0000;

  typedef struct {
    logic        err;
    logic [15:0] data;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] model_rd = 16'h0000;

  always @(posedge pin_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge pin_clk);
    #1;
  endtask

  task automatic push(input logic err, input logic [15:0] data, input int lat);
    exp_t e;
    e.err = err; e.data = data; e.lat = lat; e.start = cyc;
    sb.push_back(e);
  endtask

  // Completion monitor: every ack/err must match the oldest expected response.
  always @(negedge pin_clk) begin
    if (!pin_dclo && (req_ack || req_err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: ack=%b err=%b with empty scoreboard", req_ack, req_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_err", {31'd0, req_err}, {31'd0, e.err});
        chk("resp_ack", {31'd0, req_ack}, {31'd0, !e.err});
        chk("resp_rd_data", {16'd0, rd_data}, {16'd0, e.data});
        if (e.lat >= 0) chk("resp_latency", cyc - e.start, e.lat);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_ok;
    // Reset state
    #2;
    chk("reset_outs", ov, O_ZERO);
    chk("reset_rd_data", rd_data, 16'h0000);
    step(); step();
    pin_dclo = 1'b0;
    chk("rdy_after_release", ov, O_ZERO);
    step();
    chk("rdy_one_cycle_later", ov, O_IDLE);

    // Read 0x1000, RPLY on second DATA cycle
    req_start = 1; req_wr = 0; req_addr = 16'h1000;
    model_rd = 16'hBEEF; push(1'b0, model_rd, 6);
    step(); req_start = 0;
    chk("rd_addr", ov, 11'b000_1100_0000);
    chk("rd_addr_ad", pin_ad_out, 16'h1000);
    step(); chk("rd_asyn", ov, 11'b000_1110_0000);
    step(); chk("rd_data1", ov, O_DRD);
    step(); chk("rd_data2", ov, O_DRD);
    pin_rply = 1; pin_ad_in = 16'hBEEF;
    step(); chk("rd_dend", ov, O_DENDR);
    pin_rply = 0; pin_ad_in = 16'h0000;
    step(); chk("rd_send", ov, O_SEND);
    step(); chk("rd_ack_single_pulse", ov, O_IDLE);

    // Byte write 0x2001 / 0x00AA, RPLY held one extra cycle
    req_start = 1; req_wr = 1; req_byte = 1; req_addr = 16'h2001; req_data = 16'h00AA;
    push(1'b0, model_rd, 6);
    step(); req_start = 0;
    chk("wr_addr", ov, 11'b000_1100_0100);
    step(); chk("wr_asyn", ov, 11'b000_1110_0100);
    step(); chk("wr_data", ov, 11'b000_1110_1100);
    chk("wr_data_ad", pin_ad_out, 16'h00AA);
    pin_rply = 1;
    step(); chk("wr_dend_rply_hi", ov, O_DENDW);
    step(); chk("wr_dend_no_ack", ov, O_DENDW);
    pin_rply = 0;
    step(); chk("wr_send", ov, O_SEND);
    step(); req_wr = 0; req_byte = 0;

    // RMW at 0x3000: read 0x1234, write 0x5678 under one SYNC
    req_start = 1; req_rmw = 1; req_addr = 16'h3000; req_data = 16'h5678;
    model_rd = 16'h1234; push(1'b0, model_rd, 7);
    step(); req_start = 0;
    chk("rmw_addr", ov, 11'b000_1100_0100);
    step(); chk("rmw_asyn", ov, 11'b000_1110_0100);
    step(); chk("rmw_din", ov, O_DRD);
    pin_rply = 1; pin_ad_in = 16'h1234;
    step(); chk("rmw_dend_rd", ov, O_DENDR);
    pin_rply = 0; pin_ad_in = 16'h0000;
    step(); chk("rmw_dout", ov, 11'b000_1110_1000);
    chk("rmw_dout_ad", pin_ad_out, 16'h5678);
    pin_rply = 1;
    step(); chk("rmw_dend_wr", ov, O_DENDW);
    pin_rply = 0;
    step(); chk("rmw_send", ov, O_SEND);
    step(); req_rmw = 0;

    // IAK with stale RPLY at DATA entry; vector 0x0060
    req_start = 1; req_iak = 1; pin_rply = 1; pin_ad_in = 16'hDEAD;
    model_rd = 16'h0060; push(1'b0, model_rd, 5);
    step(); req_start = 0;
    chk("iak_data_stale", ov, 11'b000_0101_0010);
    step(); chk("iak_stale_ignored", ov, 11'b000_0101_0010);
    pin_rply = 0;
    step(); chk("iak_data3", ov, 11'b000_0101_0010);
    pin_rply = 1; pin_ad_in = 16'h0060;
    step(); chk("iak_dend", ov, 11'b000_0100_0000);
    pin_rply = 0; pin_ad_in = 16'h0000;
    step(); chk("iak_send", ov, O_SEND);
    step(); req_iak = 0;

    // No RPLY
    req_start = 1; req_addr = 16'h4000;
`ifdef AM4_QSEQ_TIMEOUT_EN
    push(1'b1, model_rd, 67);
`else
    model_rd = 16'h4444; push(1'b0, model_rd, 105);
`endif
    step(); req_start = 0;
    step(); step();
    n_ok = 0;
`ifdef AM4_QSEQ_TIMEOUT_EN
    for (int i = 0; i < 64; i++) begin
      if (ov == O_DRD) n_ok++;
      step();
    end
    chk("tout_data_cycles", n_ok, 64);
    chk("tout_send_err", ov, O_SERR);
    step(); chk("tout_idle", ov, O_IDLE);
`else
    for (int i = 0; i < 100; i++) begin
      if (ov == O_DRD) n_ok++;
      step();
    end
    chk("noto_waits", n_ok, 100);
    chk("noto_still_data", ov, O_DRD);
    pin_rply = 1; pin_ad_in = 16'h4444;
    step(); pin_rply = 0; pin_ad_in = 16'h0000;
    step(); chk("noto_send", ov, O_SEND);
    step();
`endif

    // DMA request beats same-cycle req_start
    pin_dmr = 1; req_start = 1; req_addr = 16'h5555;
    step(); req_start = 0;
    chk("dma_grant", ov, 11'b000_0000_0001);
    pin_sack = 1;
    step(); chk("dma_owned", ov, O_ZERO);
    pin_dmr = 0;
    step(); chk("dma_hold", ov, O_ZERO);
    pin_sack = 0;
    step(); chk("dma_release", ov, O_IDLE);

    // DMR withdrawn before SACK
    pin_dmr = 1;
    step(); chk("dmr_grant", ov, 11'b000_0000_0001);
    pin_dmr = 0;
    step(); chk("dmr_withdrawn", ov, O_IDLE);

    // Reset in the middle of a data phase
    req_start = 1; req_addr = 16'h6000;
    step(); req_start = 0;
    step(); step();
    chk("rst_pre_data", ov, O_DRD);
    #2 pin_dclo = 1;
    #1;
    chk("rst_async_outs", ov, O_ZERO);
    chk("rst_async_ad", pin_ad_out, 16'h0000);
    chk("rst_async_rd", rd_data, 16'h0000);
    step();
    pin_dclo = 0;
    chk("rst_release_rdy0", ov, O_ZERO);
    step(); chk("rst_release_rdy1", ov, O_IDLE);

    step(); step();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
